// File: rtl/charge_timer_multi.sv
// Multi-channel coin charging timer: per-channel binary-seconds credit, 1 Hz countdown, BCD mm:ss out.
// Optional low-time warning flags are built only when CHARGE_WARN_EN is defined.
module charge_timer_multi #(
   parameter int unsigned NUM_CH        = 2,
   parameter int unsigned CHW           = 1,
   parameter int unsigned COIN_W        = 3,
   parameter int unsigned SECS_PER_UNIT = 30,
   parameter int unsigned TICK_DIV      = 100,
   parameter int unsigned MIN_DIGITS    = 2,
   parameter int unsigned WARN_SEC      = 10
) (
   input  logic                                   Clk,
   input  logic                                   Reset,
   input  logic                                   ModeEnable,
   input  logic [CHW-1:0]                         ChSel,
   input  logic [COIN_W-1:0]                      Coin,
   input  logic                                   CoinValid,
   input  logic                                   Cancel,
   output logic [NUM_CH*(4*MIN_DIGITS+8)-1:0]     PresentTime,
   output logic [NUM_CH-1:0]                      Active,
   output logic [NUM_CH-1:0]                      Done,
   output logic                                   Overflow,
   output logic [NUM_CH-1:0]                      Warn
);

   localparam int unsigned MAX_SEC = (MIN_DIGITS == 1) ? 599 : 5999;
   localparam int unsigned TW      = $clog2(MAX_SEC + 1);
   localparam int unsigned PW      = $clog2(TICK_DIV);
   localparam int unsigned FW      = 4 * MIN_DIGITS + 8;

   typedef enum logic {IDLE = 1'b0, CHARGING = 1'b1} state_t;

   state_t            state_q [NUM_CH];
   state_t            state_d [NUM_CH];
   logic [TW-1:0]     time_q  [NUM_CH];
   logic [TW-1:0]     time_d  [NUM_CH];
   logic [PW-1:0]     pre_q, pre_d;
   logic              tick;
   logic              sel;
   logic [31:0]       credit, sum;
   logic [NUM_CH-1:0] done_d;
   logic              ovf_d;
`ifdef CHARGE_WARN_EN
   logic [NUM_CH-1:0] warn_d;
`endif

   always_comb begin
      tick   = ModeEnable && (pre_q == PW'(TICK_DIV - 1));
      pre_d  = pre_q;
      if (ModeEnable)
         pre_d = tick ? '0 : pre_q + PW'(1);
      credit = 32'(Coin) * SECS_PER_UNIT;
      sum    = '0;
      sel    = 1'b0;
      ovf_d  = 1'b0;
      done_d = '0;
`ifdef CHARGE_WARN_EN
      warn_d = '0;
`endif
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         state_d[i] = state_q[i];
         time_d[i]  = time_q[i];
         sel        = ModeEnable && (32'(ChSel) == i);
         if (sel && Cancel) begin
            state_d[i] = IDLE;
            time_d[i]  = '0;
         end else if (sel && CoinValid && (Coin != '0)) begin
            // a coincident tick is folded into the sum, so a coin at 1 s never produces Done
            sum = 32'(time_q[i]) + credit;
            if ((state_q[i] == CHARGING) && tick)
               sum = sum - 32'd1;
            if (sum > MAX_SEC) begin
               ovf_d     = 1'b1;
               time_d[i] = TW'(MAX_SEC);
            end else begin
               time_d[i] = TW'(sum);
            end
            state_d[i] = CHARGING;
         end else if ((state_q[i] == CHARGING) && tick) begin
            time_d[i] = time_q[i] - TW'(1);
            if (time_q[i] == TW'(1)) begin
               state_d[i] = IDLE;
               done_d[i]  = 1'b1;
            end
         end
`ifdef CHARGE_WARN_EN
         warn_d[i] = (state_d[i] == CHARGING) && (32'(time_d[i]) <= WARN_SEC);
`endif
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         pre_q    <= '0;
         Done     <= '0;
         Overflow <= 1'b0;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            state_q[i] <= IDLE;
            time_q[i]  <= '0;
         end
      end else begin
         pre_q    <= pre_d;
         Done     <= done_d;
         Overflow <= ovf_d;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            state_q[i] <= state_d[i];
            time_q[i]  <= time_d[i];
         end
      end
   end

`ifdef CHARGE_WARN_EN
   always_ff @(posedge Clk) begin
      if (Reset)
         Warn <= '0;
      else
         Warn <= warn_d;
   end
`else
   assign Warn = '0;
`endif

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [6:0]                mins;
      logic [5:0]                secs;
      logic [4*MIN_DIGITS-1:0]   mbcd;

      always_comb begin
         mins = 7'(32'(time_q[g]) / 60);
         secs = 6'(32'(time_q[g]) % 60);
      end

      if (MIN_DIGITS == 1) begin : g_m1
         assign mbcd = mins[3:0];
      end else begin : g_m2
         assign mbcd = {4'(mins / 7'd10), 4'(mins % 7'd10)};
      end

      assign PresentTime[g*FW +: FW] = {mbcd, 4'(secs / 6'd10), 4'(secs % 6'd10)};
      assign Active[g]               = (state_q[g] == CHARGING);
   end

endmodule

// File: tb/tb_charge_timer_multi.sv
// Scoreboard bench for charge_timer_multi: reference model pushes per-cycle expectations, a monitor pops and compares.
// Directed test-plan scenarios first, then randomized traffic; honours CHARGE_WARN_EN for the Warn outputs.
module tb_charge_timer_multi;

   localparam int NUM_CH   = 2;
   localparam int CHW      = 2;
   localparam int COIN_W   = 3;
   localparam int SPU      = 30;
   localparam int TICK_DIV = 4;
   localparam int MIN_DIG  = 2;
   localparam int WARN_SEC = 10;
   localparam int MAX_SEC  = 5999;

   logic              Clk = 1'b0;
   logic              Reset = 1'b1;
   logic              ModeEnable = 1'b0;
   logic [CHW-1:0]    ChSel = '0;
   logic [COIN_W-1:0] Coin = '0;
   logic              CoinValid = 1'b0;
   logic              Cancel = 1'b0;
   logic [31:0]       PresentTime;
   logic [1:0]        Active, Done, Warn;
   logic              Overflow;

   always #5 Clk = ~Clk;

   charge_timer_multi #(
      .NUM_CH(NUM_CH), .CHW(CHW), .COIN_W(COIN_W), .SECS_PER_UNIT(SPU),
      .TICK_DIV(TICK_DIV), .MIN_DIGITS(MIN_DIG), .WARN_SEC(WARN_SEC)
   ) dut (
      .Clk(Clk), .Reset(Reset), .ModeEnable(ModeEnable), .ChSel(ChSel),
      .Coin(Coin), .CoinValid(CoinValid), .Cancel(Cancel),
      .PresentTime(PresentTime), .Active(Active), .Done(Done),
      .Overflow(Overflow), .Warn(Warn)
   );

   typedef struct packed {
      logic [31:0] pt;
      logic [1:0]  act;
      logic [1:0]  done;
      logic [1:0]  warn;
      logic        ovf;
   } exp_t;

   exp_t sb[$];
   int   passed = 0;
   int   total  = 0;

   // reference model: remaining seconds per channel, charging flags, prescaler phase
   int   m_t[NUM_CH];
   bit   m_chg[NUM_CH];
   int   m_pre;
   bit [1:0] m_done, m_warn;
   bit   m_ovf;

   function automatic logic [15:0] bcd(input int s);
      int mm, ss;
      mm = s / 60;
      ss = s % 60;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_step();
      exp_t e;
      if (Reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            m_t[i] = 0;
            m_chg[i] = 0;
         end
         m_pre = 0; m_done = '0; m_ovf = 0;
      end else if (!ModeEnable) begin
         m_done = '0; m_ovf = 0;
      end else begin
         bit tk;
         tk = (m_pre == TICK_DIV - 1);
         m_pre = tk ? 0 : m_pre + 1;
         m_done = '0; m_ovf = 0;
         for (int i = 0; i < NUM_CH; i++) begin
            if (ChSel == i && Cancel) begin
               m_t[i] = 0;
               m_chg[i] = 0;
            end else if (ChSel == i && CoinValid && Coin != 0) begin
               int n;
               n = m_t[i] - ((m_chg[i] && tk) ? 1 : 0) + int'(Coin) * SPU;
               if (n > MAX_SEC) begin
                  m_ovf = 1;
                  n = MAX_SEC;
               end
               m_t[i] = n;
               m_chg[i] = 1;
            end else if (m_chg[i] && tk) begin
               m_t[i] = m_t[i] - 1;
               if (m_t[i] == 0) begin
                  m_chg[i] = 0;
                  m_done[i] = 1;
               end
            end
         end
      end
      for (int i = 0; i < NUM_CH; i++) begin
`ifdef CHARGE_WARN_EN
         m_warn[i] = m_chg[i] && (m_t[i] <= WARN_SEC);
`else
         m_warn[i] = 0;
`endif
      end
      e.pt   = {bcd(m_t[1]), bcd(m_t[0])};
      e.act  = {m_chg[1], m_chg[0]};
      e.done = m_done;
      e.warn = m_warn;
      e.ovf  = m_ovf;
      sb.push_back(e);
   endtask

   // monitor: one expectation per clock edge, compared a few time units after the edge
   always begin
      exp_t e;
      @(posedge Clk);
      #3;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("sb_time", PresentTime, e.pt);
         check("sb_active", 32'(Active), 32'(e.act));
         check("sb_done", 32'(Done), 32'(e.done));
         check("sb_overflow", 32'(Overflow), 32'(e.ovf));
         check("sb_warn", 32'(Warn), 32'(e.warn));
      end
   end

   task automatic step(input logic en, input logic [CHW-1:0] sel, input logic [COIN_W-1:0] c,
                       input logic cv, input logic cn);
      ModeEnable = en; ChSel = sel; Coin = c; CoinValid = cv; Cancel = cn;
      @(posedge Clk);
      model_step();
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b1, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic wait_ch(input int ch, input logic [15:0] target, input int bound, input string name);
      for (int k = 0; k < bound; k++) begin
         if (PresentTime[ch*16 +: 16] == target) break;
         idle(1);
      end
      check(name, 32'(PresentTime[ch*16 +: 16]), 32'(target));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int dcnt;
      for (int i = 0; i < NUM_CH; i++) begin m_t[i] = 0; m_chg[i] = 0; end
      m_pre = 0; m_done = '0; m_ovf = 0; m_warn = '0;

      @(negedge Clk);
      Reset = 1'b1;
      step(1'b0, '0, '0, 1'b0, 1'b0);
      step(1'b0, '0, '0, 1'b0, 1'b0);
      check("reset_time", PresentTime, 32'h0);
      check("reset_active", 32'(Active), 32'h0);
      check("reset_done", 32'(Done), 32'h0);
      check("reset_ovf", 32'(Overflow), 32'h0);
      Reset = 1'b0;

      // 1: first coin and first tick
      step(1'b1, 2'd0, 3'd5, 1'b1, 1'b0);
      check("t1_load", 32'(PresentTime[15:0]), 32'h0230);
      check("t1_active", 32'(Active), 32'h1);
      idle(3);
      check("t1_tick", 32'(PresentTime[15:0]), 32'h0229);

      // 2: count out to zero
      wait_ch(0, 16'h0002, 700, "t2_reach2");
      dcnt = 0;
      for (int k = 0; k < 8; k++) begin
         idle(1);
         if (Done[0]) dcnt++;
         if (k == 3) check("t2_one", 32'(PresentTime[15:0]), 32'h0001);
      end
      check("t2_zero", 32'(PresentTime[15:0]), 32'h0000);
      check("t2_inactive", 32'(Active[0]), 32'h0);
      check("t2_done_once", 32'(dcnt), 32'd1);

      // 3: saturation on ch1
      for (int k = 0; k < 29; k++) step(1'b1, 2'd1, 3'd7, 1'b1, 1'b0);
      wait_ch(1, 16'h9930, 400, "t3_reach9930");
      step(1'b1, 2'd1, 3'd7, 1'b1, 1'b0);
      check("t3_sat", 32'(PresentTime[31:16]), 32'h9959);
      check("t3_ovf", 32'(Overflow), 32'h1);
      step(1'b1, 2'd1, 3'd1, 1'b1, 1'b0);
      check("t3_sat2", 32'(PresentTime[31:16]), 32'h9959);
      check("t3_ovf2", 32'(Overflow), 32'h1);
      idle(1);
      check("t3_ovf_clear", 32'(Overflow), 32'h0);

      // 4: freeze
      step(1'b1, 2'd0, 3'd2, 1'b1, 1'b0);
      check("t4_load", 32'(PresentTime[15:0]), 32'h0100);
      for (int k = 0; k < 40; k++) step(1'b0, 2'd0, (k == 20) ? 3'd3 : 3'd0, (k == 20), 1'b0);
      check("t4_frozen", 32'(PresentTime[15:0]), 32'h0100);
      check("t4_active", 32'(Active[0]), 32'h1);
      wait_ch(0, 16'h0059, 4, "t4_resume");

      // 5: same-cycle events
      step(1'b1, 2'd0, 3'd3, 1'b1, 1'b1);
      check("t5_cancel_time", 32'(PresentTime[15:0]), 32'h0);
      check("t5_cancel_idle", 32'(Active[0]), 32'h0);
      check("t5_cancel_nodone", 32'(Done[0]), 32'h0);
      step(1'b1, 2'd0, 3'd1, 1'b1, 1'b0);
      wait_ch(0, 16'h0001, 200, "t5_reach1");
      idle(3);
      step(1'b1, 2'd0, 3'd1, 1'b1, 1'b0);
      check("t5_tickcoin", 32'(PresentTime[15:0]), 32'h0030);
      check("t5_nodone", 32'(Done[0]), 32'h0);
      check("t5_active", 32'(Active[0]), 32'h1);

      // 6: reset mid-countdown
      Reset = 1'b1;
      idle(1);
      Reset = 1'b0;
      check("t6_time", PresentTime, 32'h0);
      check("t6_active", 32'(Active), 32'h0);
      check("t6_done", 32'(Done), 32'h0);
      check("t6_ovf", 32'(Overflow), 32'h0);
      check("t6_warn", 32'(Warn), 32'h0);

      // out-of-range channel select is ignored
      step(1'b1, 2'd3, 3'd7, 1'b1, 1'b0);
      check("oor_active", 32'(Active), 32'h0);
      check("oor_time", PresentTime, 32'h0);

`ifdef CHARGE_WARN_EN
      step(1'b1, 2'd0, 3'd1, 1'b1, 1'b0);
      wait_ch(0, 16'h0011, 200, "warn_reach11");
      check("warn_off", 32'(Warn[0]), 32'h0);
      idle(4);
      check("warn_time", 32'(PresentTime[15:0]), 32'h0010);
      check("warn_on", 32'(Warn[0]), 32'h1);
`endif

      // randomized traffic
      for (int k = 0; k < 4000; k++) begin
         Reset = ($urandom_range(0, 799) == 0);
         step(($urandom_range(0, 9) != 0), CHW'($urandom_range(0, 3)), COIN_W'($urandom_range(0, 7)),
              ($urandom_range(0, 59) == 0), ($urandom_range(0, 79) == 0));
      end
      Reset = 1'b0;
      idle(2);
      #5;
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
